// File: rtl/gemac_rx_ll8_framer_pkg.sv
// Shared definitions for the GEMAC rx LocalLink-8 framer: FSM states, FIFO entry layout, FCS length.
// The hold depth depends on GEMAC_RX_STRIP_FCS_EN (defined: 5-deep hold that swallows the FCS).
package gemac_rx_ll8_framer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FRAME   = 2'd1,
        ST_OVERRUN = 2'd2,
        ST_FLUSH   = 2'd3
    } state_t;

    localparam int ENTRY_W = 10;
    localparam int EOF_BIT = 9;
    localparam int ERR_BIT = 8;
    localparam int FCS_LEN = 4;

`ifdef GEMAC_RX_STRIP_FCS_EN
    localparam int HOLD_DEPTH = FCS_LEN + 1;
`else
    localparam int HOLD_DEPTH = 1;
`endif

    function automatic logic [ENTRY_W-1:0] make_entry(input logic eof, input logic err,
                                                       input logic [7:0] data);
        logic [ENTRY_W-1:0] e;
        e          = '0;
        e[EOF_BIT] = eof;
        e[ERR_BIT] = err;
        e[7:0]     = data;
        return e;
    endfunction

endpackage

// File: rtl/gemac_rx_ll8_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers are one bit wider than the address so
// full/empty come from comparing the wrap bit. A write at full is allowed when a read frees a slot.
module gemac_rx_ll8_fifo #(
    parameter int AW = 11,
    parameter int W  = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [2**AW];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         wr_ok;
    logic         rd_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_ok   = rd_en & ~empty;
    assign wr_ok   = wr_en & (~full | rd_ok);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/gemac_rx_ll8_framer.sv
// Converts the GEMAC rx byte stream into LocalLink-8 frames through an overflow-tolerant byte FIFO.
// Optional GEMAC_RX_STRIP_FCS_EN removes the trailing 4 FCS bytes from good frames.
module gemac_rx_ll8_framer
    import gemac_rx_ll8_framer_pkg::*;
#(
    parameter int FIFO_AW = 11
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_error,
    input  logic        rx_ack,
    output logic [7:0]  ll_data,
    output logic        ll_sof,
    output logic        ll_eof,
    output logic        ll_error,
    output logic        ll_src_rdy,
    input  logic        ll_dst_rdy,
    output logic        overrun,
    output logic [15:0] drop_cnt
);

    localparam int              HCW       = $clog2(HOLD_DEPTH + 1);
    localparam logic [HCW-1:0]  HOLD_FULL = HCW'(HOLD_DEPTH);
    localparam logic [HCW-1:0]  HOLD_ONE  = HCW'(1);

    state_t               state, state_nxt;
    logic [7:0]           hold_data [HOLD_DEPTH];
    logic [HCW-1:0]       hold_cnt;
    logic [7:0]           oldest_byte;
    logic                 skip, skip_nxt;
    logic                 err_q;
    logic                 sof_next;

    logic                 fifo_full, fifo_empty, full_eff, pop;
    logic                 push, accept, lose, drop_inc, hold_clr;
    logic [ENTRY_W-1:0]   push_data, fifo_rd_data;
    logic                 rx_end;

    gemac_rx_ll8_fifo #(.AW(FIFO_AW), .W(ENTRY_W)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .wr_en   (push),
        .wr_data (push_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Outputs are forced to zero while empty so nothing stale leaks out after reset.
    assign ll_src_rdy = ~fifo_empty;
    assign ll_data    = fifo_empty ? 8'h00 : fifo_rd_data[7:0];
    assign ll_eof     = ~fifo_empty & fifo_rd_data[EOF_BIT];
    assign ll_error   = ~fifo_empty & fifo_rd_data[ERR_BIT];
    assign ll_sof     = ~fifo_empty & sof_next;
    assign pop        = ll_src_rdy & ll_dst_rdy;
    assign full_eff   = fifo_full & ~pop;
    assign rx_end     = rx_ack | rx_error | ((state == ST_FRAME) & ~rx_valid);

    always_comb begin
        oldest_byte = hold_data[0];
        for (int i = 0; i < HOLD_DEPTH; i++) begin
            if (int'(hold_cnt) == i + 1) oldest_byte = hold_data[i];
        end
    end

    always_comb begin
        state_nxt = state;
        skip_nxt  = skip;
        push      = 1'b0;
        push_data = '0;
        accept    = 1'b0;
        lose      = 1'b0;
        drop_inc  = 1'b0;
        hold_clr  = 1'b0;
        case (state)
            ST_IDLE: begin
                // skip marks a frame that began while we were still flushing an overrun
                if (skip) begin
                    if (rx_ack || rx_error || !rx_valid) begin
                        skip_nxt = 1'b0;
                        drop_inc = 1'b1;
                    end
                end else if (rx_ack || rx_error) begin
                    drop_inc = rx_ack | ~err_q;
                end else if (rx_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_FRAME;
                end
            end
            ST_FRAME: begin
                if (rx_end) begin
                    hold_clr  = 1'b1;
                    state_nxt = ST_IDLE;
                    if (rx_ack && hold_cnt != HOLD_FULL) begin
                        drop_inc = 1'b1;
                    end else if (full_eff) begin
                        lose      = 1'b1;
                        drop_inc  = 1'b1;
                        state_nxt = ST_FLUSH;
                    end else begin
                        push      = 1'b1;
                        push_data = make_entry(1'b1, ~rx_ack, oldest_byte);
                    end
                end else if (hold_cnt == HOLD_FULL) begin
                    if (full_eff) begin
                        lose      = 1'b1;
                        hold_clr  = 1'b1;
                        state_nxt = ST_OVERRUN;
                    end else begin
                        accept    = 1'b1;
                        push      = 1'b1;
                        push_data = make_entry(1'b0, 1'b0, hold_data[HOLD_DEPTH-1]);
                    end
                end else begin
                    accept = 1'b1;
                end
            end
            ST_OVERRUN: begin
                if (rx_ack || rx_error || !rx_valid) begin
                    drop_inc  = 1'b1;
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (rx_valid) skip_nxt = 1'b1;
                if (!full_eff) begin
                    push      = 1'b1;
                    push_data = make_entry(1'b1, 1'b1, 8'h00);
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            skip     <= 1'b0;
            err_q    <= 1'b0;
            sof_next <= 1'b1;
            overrun  <= 1'b0;
            drop_cnt <= '0;
        end else if (clear) begin
            state    <= ST_IDLE;
            skip     <= 1'b0;
            err_q    <= 1'b0;
            sof_next <= 1'b1;
            overrun  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state   <= state_nxt;
            skip    <= skip_nxt;
            err_q   <= rx_error;
            overrun <= lose;
            if (pop) sof_next <= ll_eof;
            if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // Newest byte enters slot 0; once the hold is full the oldest sits in the last slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt <= '0;
            for (int i = 0; i < HOLD_DEPTH; i++) hold_data[i] <= 8'h00;
        end else if (clear || hold_clr) begin
            hold_cnt <= '0;
        end else if (accept) begin
            hold_data[0] <= rx_data;
            for (int i = HOLD_DEPTH - 1; i > 0; i--) hold_data[i] <= hold_data[i-1];
            if (hold_cnt != HOLD_FULL) hold_cnt <= hold_cnt + HOLD_ONE;
        end
    end

endmodule
